// File: rtl/mux_4x1.sv
// Registered 4:1 multiplexer: one-cycle capture of the selected input, with
// a valid strobe and a registered copy of the select that produced y.

module mux_4x1_lane (
    input  logic [3:0] din,
    input  logic [1:0] sel,
    output logic       dout
);
    assign dout = din[sel];
endmodule

module mux_4x1 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       sel_q
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] y_d;

    assign sel = {s1, s2};

    // One lane per data bit; every lane sees the same select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux_4x1_lane u_lane (
            .din  ({d[i], c[i], b[i], a[i]}),
            .sel  (sel),
            .dout (y_d[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= RESET_VAL;
            sel_q   <= 2'b00;
            y_valid <= 1'b0;
        end else begin
            y_valid <= en;
            if (en) begin
                y     <= y_d;
                sel_q <= sel;
            end
        end
    end
endmodule

// File: tb/tb_mux_4x1.sv
// Scoreboard bench for mux_4x1: a 1-bit and an 8-bit instance share controls;
// expected captures are queued at issue time and popped when y_valid shows.

module tb_mux_4x1;
    typedef struct packed {
        logic       y1;
        logic [7:0] y8;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, s1, s2;
    logic       a1, b1, c1, d1;
    logic [7:0] a8, b8, c8, d8;
    logic       y1, v1, y8v;
    logic [7:0] y8;
    logic [1:0] sq1, sq8;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mux_4x1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .c(c1), .d(d1),
        .s1(s1), .s2(s2), .y(y1), .y_valid(v1), .sel_q(sq1)
    );

    mux_4x1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .c(c8), .d(d8),
        .s1(s1), .s2(s2), .y(y8), .y_valid(y8v), .sel_q(sq8)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic ey1, input logic [7:0] ey8,
                               input logic [1:0] esel, input logic ev);
        check({tag, " y1"},    {7'd0, y1},  {7'd0, ey1});
        check({tag, " y8"},    y8,          ey8);
        check({tag, " sel1"},  {6'd0, sq1}, {6'd0, esel});
        check({tag, " sel8"},  {6'd0, sq8}, {6'd0, esel});
        check({tag, " vld1"},  {7'd0, v1},  {7'd0, ev});
        check({tag, " vld8"},  {7'd0, y8v}, {7'd0, ev});
    endtask

    // Enabled capture with hand-computed expected outputs.
    task automatic cap(input logic [1:0] s, input logic ey1, input logic [7:0] ey8);
        en = 1'b1;
        {s1, s2} = s;
        q.push_back('{y1: ey1, y8: ey8, sel: s});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] s);
        en = 1'b0;
        {s1, s2} = s;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per valid output cycle.
    always @(negedge clk) begin
        if (v1 || y8v) begin
            check("mon vld1", {7'd0, v1},  8'd1);
            check("mon vld8", {7'd0, y8v}, 8'd1);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon: valid output with empty queue, y8=%h", y8);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("mon y1",   {7'd0, y1},  {7'd0, e.y1});
                check("mon y8",   y8,          e.y8);
                check("mon sel1", {6'd0, sq1}, {6'd0, e.sel});
                check("mon sel8", {6'd0, sq8}, {6'd0, e.sel});
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; s1 = 1'b0; s2 = 1'b0;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b1;
        a8 = 8'hA5; b8 = 8'h3C; c8 = 8'h0F; d8 = 8'hF0;
        #1;
        check_state("reset async", 1'b0, 8'h00, 2'b00, 1'b0);

        // Reset wins over en across several edges.
        en = 1'b1; s1 = 1'b1; s2 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_state("reset hold", 1'b0, 8'h00, 2'b00, 1'b0);
        end
        rst = 1'b0;

        // First enabled edge after reset, then all four selects back to back.
        cap(2'b11, 1'b1, 8'hF0);
        cap(2'b00, 1'b1, 8'hA5);
        cap(2'b01, 1'b0, 8'h3C);
        cap(2'b10, 1'b1, 8'h0F);
        cap(2'b11, 1'b1, 8'hF0);
        cap(2'b01, 1'b0, 8'h3C);

        // Disabled edge: toggling b must not reach y.
        b1 = 1'b1; b8 = 8'hFF;
        idle(2'b01);
        check_state("hold en0", 1'b0, 8'h3C, 2'b01, 1'b0);
        b1 = 1'b0; b8 = 8'h00;
        idle(2'b01);
        check_state("hold en0 b", 1'b0, 8'h3C, 2'b01, 1'b0);
        b1 = 1'b0; b8 = 8'h3C;

        // Reset between edges while y=1, after the output was consumed.
        cap(2'b00, 1'b1, 8'hA5);
        en = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_state("rst mid", 1'b0, 8'h00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap(2'b10, 1'b1, 8'h0F);

        // Reset before the pending output is seen discards it.
        cap(2'b11, 1'b1, 8'hF0);
        en = 1'b0;
        rst = 1'b1;
        q.delete();
        #1;
        check_state("rst discard", 1'b0, 8'h00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap(2'b01, 1'b0, 8'h3C);
        en = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("queue empty", 8'(q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_4x1.md
MUX_4X1 -- requirements
Module: mux_4x1

Interface
REQ-001 Parameter: WIDTH, default 1, data width of every data input and of y.
REQ-002 Parameter: RESET_VAL, default 0 (WIDTH bits), value loaded into y on reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  capture enable; the input is sampled when en=1.
REQ-006 a  input  WIDTH  data input 0, selected when {s1,s2}=00.
REQ-007 b  input  WIDTH  data input 1, selected when {s1,s2}=01.
REQ-008 c  input  WIDTH  data input 2, selected when {s1,s2}=10.
REQ-009 d  input  WIDTH  data input 3, selected when {s1,s2}=11.
REQ-010 s1  input  1  select MSB.
REQ-011 s2  input  1  select LSB.
REQ-012 y  output  WIDTH  registered mux output.
REQ-013 y_valid  output  1  high for the cycle after a capture, otherwise low.
REQ-014 sel_q  output  2  registered copy of {s1,s2} that produced the current y.

Function
REQ-015 Selection SHALL be: 00->a, 01->b, 10->c, 11->d, with s1 as MSB and s2 as LSB, applied identically to every bit of WIDTH.
REQ-016 On a rising clk edge with en=1 and rst=0, y SHALL load the selected input, sel_q SHALL load {s1,s2}, and y_valid SHALL become 1.
REQ-017 On a rising clk edge with en=0 and rst=0, y and sel_q SHALL hold their values and y_valid SHALL become 0.
REQ-018 Latency from sampled inputs to y SHALL be exactly 1 clock cycle; there SHALL be no combinational path from any input to y, y_valid or sel_q.
REQ-019 Changes on a..d, s1 or s2 between clock edges SHALL have no effect on the outputs until the next enabled edge.
REQ-020 When en=1 on consecutive edges, y SHALL update every cycle and y_valid SHALL remain 1.
REQ-021 An X or Z on s1 or s2 during an enabled edge SHALL NOT be specified; the bench SHALL drive only 0 and 1 on the selects.
REQ-022 No other state SHALL exist; the block SHALL have no FSM beyond the output registers.

Reset
REQ-023 While rst=1, y SHALL equal RESET_VAL, sel_q SHALL equal 00 and y_valid SHALL equal 0, and they SHALL take these values immediately, independent of clk.
REQ-024 Reset SHALL take priority over en.
REQ-025 After rst deasserts, the first rising edge with en=1 SHALL produce a valid output with normal 1-cycle latency.
REQ-026 A reset asserted mid-operation SHALL discard the pending output, and y_valid SHALL drop to 0 at once.

Verification
REQ-027 Inputs a=1, b=0, c=1, d=1 with en=1 and {s1,s2}=00 -> after 1 edge: y=1, sel_q=00, y_valid=1.
REQ-028 Same data with {s1,s2} stepped 01, 10, 11 on successive edges (10 ns apart) -> y=0, then 1, then 1; sel_q tracks 01, 10, 11; y_valid stays 1.
REQ-029 With {s1,s2}=01 and en=0, toggle b -> y, sel_q unchanged; y_valid=0 after the edge.
REQ-030 Assert rst between clock edges while y=1 -> y=RESET_VAL(0), sel_q=00 and y_valid=0 immediately, without waiting for a clk edge.
REQ-031 WIDTH=8 with a=8'hA5, b=8'h3C, c=8'h0F, d=8'hF0 and all four selects -> y equals the matching byte one cycle later each time.
REQ-032 Hold rst=1 and en=1 over several edges -> outputs stay at their reset values; release rst -> the next enabled edge gives the correct y.
